uart_cmd_sequencer: RTL and testbench

Consumes the byte stream from the UART receiver (8-bit data plus a one-cycle valid strobe) and frames it into register-access commands.
- Write commands issue a one-cycle register write strobe.
- Read commands issue a register read strobe, then hand the returned byte to the UART transmitter over a valid/ready handshake.
- An inter-byte timeout recovers framing after line noise or partial commands.
- The block sits between uart_rx and the design's control register file.

---
 rtl/uart_cmd_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_uart_cmd_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_sequencer.sv
// Purpose : frames the uart_rx byte stream into register write/read commands
//           and returns read data to the UART transmitter.
// Latency : write strobe 1 clk after the last command byte; read strobe 1 clk
//           after it; response valid 2 clks after the read strobe.
// Backpressure: response held in RESP until tx_ready_i; bytes arriving while a
//           command executes are dropped and flagged on error_o.
//
// Ports:
//   clock, reset_n            clock and synchronous active-low reset
//   rx_data_i / rx_valid_i    received byte and its one-cycle strobe
//   reg_addr_o / reg_wdata_o  register address and write data (held between commands)
//   reg_we_o / reg_re_o       one-cycle write / read strobes
//   reg_rdata_i               read data, valid one cycle after reg_re_o
//   tx_data_o / tx_valid_o / tx_ready_i   response handshake to uart_tx
//   error_o                   one-cycle pulse on any framing error
//   busy_o                    high whenever a command is in progress
//
// Optional build macro: UART_CMD_CHECKSUM_EN adds a trailing checksum byte to
// every command (write: op^addr^data, read: op^addr), checked in state CHK.

module uart_cmd_sequencer #(
  parameter int         TIMEOUT_CLOCKS = 1000,
  parameter logic [7:0] OP_WRITE       = 8'h57,
  parameter logic [7:0] OP_READ        = 8'h52
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  output logic       reg_we_o,
  output logic       reg_re_o,
  input  logic [7:0] reg_rdata_i,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic       error_o,
  output logic       busy_o
);

  localparam int            CW       = $clog2(TIMEOUT_CLOCKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CLOCKS - 1);

`ifdef UART_CMD_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, ADDR, DATA, CHK, EXEC_WR, EXEC_RD, CAPTURE, RESP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, ADDR, DATA, EXEC_WR, EXEC_RD, CAPTURE, RESP
  } state_t;
`endif

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          is_wr_q, is_wr_n;
  logic [7:0]    addr_q, addr_n;
  logic [7:0]    wdata_q, wdata_n;
  logic [7:0]    txd_q, txd_n;
  logic          err_q, err_n;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]    chk_q, chk_n;
`endif

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      is_wr_q <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      txd_q   <= 8'h00;
      err_q   <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
      chk_q   <= 8'h00;
`endif
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      is_wr_q <= is_wr_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      txd_q   <= txd_n;
      err_q   <= err_n;
`ifdef UART_CMD_CHECKSUM_EN
      chk_q   <= chk_n;
`endif
    end
  end

  // Next-state logic. err_n is a single OR'd flag, so coincident error
  // causes still give one pulse.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    is_wr_n = is_wr_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    txd_n   = txd_q;
    err_n   = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
    chk_n   = chk_q;
`endif

    case (state_q)
      IDLE: begin
        cnt_n = '0;
        if (rx_valid_i) begin
          if (rx_data_i == OP_WRITE || rx_data_i == OP_READ) begin
            is_wr_n = (rx_data_i == OP_WRITE);
            state_n = ADDR;
`ifdef UART_CMD_CHECKSUM_EN
            chk_n   = rx_data_i;
`endif
          end else begin
            err_n = 1'b1;
          end
        end
      end

`ifdef UART_CMD_CHECKSUM_EN
      ADDR, DATA, CHK: begin
`else
      ADDR, DATA: begin
`endif
        if (rx_valid_i) begin
          // A byte in the expiry cycle still counts: the byte check comes first.
          cnt_n = '0;
          if (state_q == ADDR) begin
            addr_n = rx_data_i;
`ifdef UART_CMD_CHECKSUM_EN
            chk_n   = chk_q ^ rx_data_i;
            state_n = is_wr_q ? DATA : CHK;
`else
            state_n = is_wr_q ? DATA : EXEC_RD;
`endif
          end else if (state_q == DATA) begin
            wdata_n = rx_data_i;
`ifdef UART_CMD_CHECKSUM_EN
            chk_n   = chk_q ^ rx_data_i;
            state_n = CHK;
`else
            state_n = EXEC_WR;
`endif
          end
`ifdef UART_CMD_CHECKSUM_EN
          else begin
            if (rx_data_i == chk_q) begin
              state_n = is_wr_q ? EXEC_WR : EXEC_RD;
            end else begin
              err_n   = 1'b1;
              state_n = IDLE;
            end
          end
`endif
        end else if (cnt_q == CNT_LAST) begin
          state_n = IDLE;
          err_n   = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end

      EXEC_WR: begin
        state_n = IDLE;
        err_n   = rx_valid_i;
      end

      EXEC_RD: begin
        state_n = CAPTURE;
        err_n   = rx_valid_i;
      end

      CAPTURE: begin
        txd_n   = reg_rdata_i;
        state_n = RESP;
        err_n   = rx_valid_i;
      end

      RESP: begin
        if (tx_ready_i) begin
          state_n = IDLE;
        end
        err_n = rx_valid_i;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Strobes decode directly from state, so they are one cycle wide and
  // mutually exclusive by construction.
  assign reg_we_o    = (state_q == EXEC_WR);
  assign reg_re_o    = (state_q == EXEC_RD);
  assign tx_valid_o  = (state_q == RESP);
  assign busy_o      = (state_q != IDLE);
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;
  assign tx_data_o   = txd_q;
  assign error_o     = err_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Purpose : scoreboard bench for uart_cmd_sequencer (TIMEOUT_CLOCKS = 16).
// Latency : expected events carry the exact cycle they must appear in.
// Backpressure: tx_ready_i is driven low then released to exercise RESP hold.

module tb_uart_cmd_sequencer;

  localparam logic [7:0] OPW = 8'h57;
  localparam logic [7:0] OPR = 8'h52;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic [7:0] reg_addr_o;
  logic [7:0] reg_wdata_o;
  logic       reg_we_o;
  logic       reg_re_o;
  logic [7:0] reg_rdata_i = 8'hEE;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i;
  logic       error_o;
  logic       busy_o;

  uart_cmd_sequencer #(.TIMEOUT_CLOCKS(16)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rx_data_i   (rx_data_i),
    .rx_valid_i  (rx_valid_i),
    .reg_addr_o  (reg_addr_o),
    .reg_wdata_o (reg_wdata_o),
    .reg_we_o    (reg_we_o),
    .reg_re_o    (reg_re_o),
    .reg_rdata_i (reg_rdata_i),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i),
    .error_o     (error_o),
    .busy_o      (busy_o)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Register file model: read data appears exactly one cycle after reg_re_o.
  logic [7:0] mem [256];
  always @(posedge clock) reg_rdata_i <= reg_re_o ? mem[reg_addr_o] : 8'hEE;

  // kind: 0 error, 1 write, 2 read strobe, 3 tx accept
  typedef struct {
    int         kind;
    logic [7:0] a;
    logic [7:0] d;
    int         c;
  } ev_t;
  ev_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] a, input logic [7:0] d, input int c);
    ev_t e;
    e.kind = kind; e.a = a; e.d = d; e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic got(input int kind, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d a=%0h d=%0h at cycle %0d, expected none",
               kind, a, d, cyc);
    end else begin
      e = exp_q.pop_front();
      check("evt_kind",  kind, e.kind);
      check("evt_cycle", cyc,  e.c);
      check("evt_addr",  a,    e.a);
      check("evt_data",  d,    e.d);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  logic       prev_tv = 1'b0, prev_acc = 1'b0;
  logic [7:0] prev_txd = 8'h00;
  int         tv_run = 0, tv_last = 0;
  always @(negedge clock) begin
    if (error_o)                 got(0, 8'h00, 8'h00);
    if (reg_we_o)                got(1, reg_addr_o, reg_wdata_o);
    if (reg_re_o)                got(2, reg_addr_o, 8'h00);
    if (tx_valid_o && tx_ready_i) got(3, 8'h00, tx_data_o);
    if (reg_we_o || reg_re_o)    check("strobe_excl", {31'd0, reg_we_o & reg_re_o}, 0);
    if (prev_tv && !prev_acc && reset_n) begin
      check("tx_hold",   {31'd0, tx_valid_o}, 1);
      check("tx_stable", {24'd0, tx_data_o}, {24'd0, prev_txd});
    end
    prev_tv  = tx_valid_o;
    prev_acc = tx_valid_o && tx_ready_i;
    prev_txd = tx_data_o;
    if (tx_valid_o) tv_run++;
    else if (tv_run != 0) begin
      tv_last = tv_run;
      tv_run  = 0;
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_at(input int t, input logic [7:0] b);
    wait_cyc(t);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    @(posedge clock);
    #1;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"},  {24'd0, reg_addr_o},  0);
    check({tag, "_wdata"}, {24'd0, reg_wdata_o}, 0);
    check({tag, "_txd"},   {24'd0, tx_data_o},   0);
    check({tag, "_ctl"},   {27'd0, reg_we_o, reg_re_o, tx_valid_o, error_o, busy_o}, 0);
  endtask

  // Write command, bytes spaced 'gap' clocks; strobe 1 clk after the last byte.
  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int gap);
    int b;
    int last;
    b = cyc + 2;
`ifdef UART_CMD_CHECKSUM_EN
    last = b + 3 * gap;
`else
    last = b + 2 * gap;
`endif
    push(1, a, d, last + 1);
    send_at(b, OPW);
    send_at(b + gap, a);
    send_at(b + 2 * gap, d);
`ifdef UART_CMD_CHECKSUM_EN
    send_at(last, OPW ^ a ^ d);
`endif
    wait_cyc(last + 3);
    check("wr_busy_after", {31'd0, busy_o}, 0);
    check("wr_addr_hold",  {24'd0, reg_addr_o},  {24'd0, a});
    check("wr_wdata_hold", {24'd0, reg_wdata_o}, {24'd0, d});
  endtask

  // Read command; tx_ready_i released 'hold' cycles after tx_valid_o rises.
  // ov > 0 injects an overrun byte ov cycles into RESP (ov + 1 < hold).
  task automatic do_read(input logic [7:0] a, input logic [7:0] exp_d,
                         input int hold, input int ov);
    int b;
    int last;
    b = cyc + 2;
    tx_ready_i = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
    last = b + 2;
`else
    last = b + 1;
`endif
    push(2, a, 8'h00, last + 1);
    if (ov > 0) push(0, 8'h00, 8'h00, last + 4 + ov);
    push(3, 8'h00, exp_d, last + 3 + hold);
    send_at(b, OPR);
    send_at(b + 1, a);
`ifdef UART_CMD_CHECKSUM_EN
    send_at(last, OPR ^ a);
`endif
    if (ov > 0) send_at(last + 3 + ov, 8'h99);
    wait_cyc(last + 3 + hold);
    tx_ready_i = 1'b1;
    @(posedge clock);
    #1;
    tx_ready_i = 1'b0;
    wait_cyc(last + 5 + hold);
    check("rd_tv_len",     tv_last, hold + 1);
    check("rd_busy_after", {31'd0, busy_o}, 0);
  endtask

  initial begin
    int b;
    int s;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h22] = 8'h3C;
    mem[8'h33] = 8'h5A;
    reset_n    = 1'b0;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    tx_ready_i = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;
    wait_cyc(cyc + 2);

    // Write, spacing kept inside the 16-clock inter-byte window.
    do_write(8'h10, 8'hA5, 12);

    // Read with 5 cycles of backpressure -> tx_valid_o high 6 cycles.
    do_read(8'h22, 8'h3C, 5, 0);

    // Unknown opcode, then a normal write.
    b = cyc + 2;
    push(0, 8'h00, 8'h00, b + 1);
    send_at(b, 8'h41);
    do_write(8'h01, 8'h02, 1);

    // Timeout: address strobe at s, 16 silent cycles s+1..s+16, error at s+17.
    b = cyc + 2;
    s = b + 4;
    push(0, 8'h00, 8'h00, s + 17);
    send_at(b, OPW);
    send_at(s, 8'h10);
    wait_cyc(s + 8);
    check("to_busy_wait", {31'd0, busy_o}, 1);
    wait_cyc(s + 20);
    check("to_busy_after", {31'd0, busy_o}, 0);

    // Byte in the expiry cycle (s+16) is accepted, no error.
    b = cyc + 2;
    s = b + 4;
`ifdef UART_CMD_CHECKSUM_EN
    push(1, 8'h10, 8'hA5, s + 19);
`else
    push(1, 8'h10, 8'hA5, s + 17);
`endif
    send_at(b, OPW);
    send_at(s, 8'h10);
    send_at(s + 16, 8'hA5);
`ifdef UART_CMD_CHECKSUM_EN
    send_at(s + 18, OPW ^ 8'h10 ^ 8'hA5);
`endif
    wait_cyc(s + 22);
    check("exp_busy_after", {31'd0, busy_o}, 0);

    // Overrun byte 99 during RESP: error pulse, response still 5A.
    do_read(8'h33, 8'h5A, 6, 2);

    // Reset in DATA discards the command and zeroes the outputs.
    b = cyc + 2;
    send_at(b, OPW);
    send_at(b + 2, 8'h05);
    wait_cyc(b + 5);
    check("pre_rst_addr", {24'd0, reg_addr_o}, 32'h05);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    check_all_zero("mid_reset");
    do_write(8'h05, 8'h06, 2);

`ifdef UART_CMD_CHECKSUM_EN
    // Checksum mismatch: error after the checksum byte, no strobe.
    b = cyc + 2;
    push(0, 8'h00, 8'h00, b + 4);
    send_at(b, OPW);
    send_at(b + 1, 8'h10);
    send_at(b + 2, 8'hA5);
    send_at(b + 3, 8'h00);
    wait_cyc(b + 6);
    check("chk_busy_after", {31'd0, busy_o}, 0);
`endif

    wait_cyc(cyc + 5);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
